// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, fetch-stage state type,
// the NOP word and a small PC alignment helper.
package cpu_pkg;

   localparam logic [5:0] OP_R_TYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI   = 6'b010011;
   localparam logic [5:0] OP_BEQ    = 6'b011001;
   localparam logic [5:0] OP_LW     = 6'b011000;
   localparam logic [5:0] OP_SW     = 6'b101000;

   // The all-zero word doubles as the program terminator and as a bubble.
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } if_state_t;

   // Instruction addresses are word aligned, so the low two bits are dropped.
   function automatic logic [31:0] alignPc(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's control, instruction-memory and IF/ID signals.
// The slave side is the fetch stage itself; the master side drives it.
interface if_stage_if;

   logic        stall_i;
   logic        flush_i;
   logic [31:0] branch_target_i;
   logic [31:0] instr_i;
   logic [31:0] pc_o;
   logic [31:0] ifid_instr_o;
   logic [31:0] ifid_pc4_o;
   logic        ifid_valid_o;
   logic        done_o;

   modport slave (
      input  stall_i,
      input  flush_i,
      input  branch_target_i,
      input  instr_i,
      output pc_o,
      output ifid_instr_o,
      output ifid_pc4_o,
      output ifid_valid_o,
      output done_o
   );

   modport master (
      output stall_i,
      output flush_i,
      output branch_target_i,
      output instr_i,
      input  pc_o,
      input  ifid_instr_o,
      input  ifid_pc4_o,
      input  ifid_valid_o,
      input  done_o
   );

endinterface

// File: rtl/if_pc_reg.sv
// Program counter register with its next-PC selection: a redirect wins over
// a hold, and otherwise the PC steps to the next word (wrapping at 2^32).
module if_pc_reg
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_n,
   input  logic        i_flush,
   input  logic        i_hold,
   input  logic [31:0] i_target,
   output logic [31:0] o_pc
);

   logic [31:0] r_pc;
   logic [31:0] w_pcNext;

   // Pick the next fetch address: aligned branch target, same PC, or PC+4.
   always_comb begin
      w_pcNext = r_pc + 32'd4;
      if (i_flush) begin
         w_pcNext = alignPc(i_target);
      end else if (i_hold) begin
         w_pcNext = r_pc;
      end
   end

   // The PC itself; reset takes effect immediately, not at the next edge.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= RESET_PC;
      end else begin
         r_pc <= w_pcNext;
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage. Fetches from pc_o every cycle, fills the IF/ID
// register, and after seeing the all-zero terminator word keeps fetching for
// DRAIN_CYCLES more cycles before freezing with done_o set.
module if_stage
   import cpu_pkg::*;
#(
   parameter int          DRAIN_CYCLES = 4,
   parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_n,
   if_stage_if.slave   bus
);

   // Counter only has to reach DRAIN_CYCLES-1; keep at least one bit.
   localparam int                CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

   if_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_ifidInstr;
   logic [31:0]      r_ifidPc4;
   logic             r_ifidValid;
   logic             r_done;

   logic [31:0]      w_pc;
   logic [31:0]      w_pcPlus4;
   logic             w_flush;
   logic             w_hold;
   logic             w_advance;
   logic             w_zeroWord;

   // Once DONE, stall and flush are ignored and everything stays frozen.
   assign w_flush    = bus.flush_i && (r_state != DONE);
   assign w_hold     = (r_state == DONE) || bus.stall_i;
   assign w_advance  = !w_flush && !w_hold;
   assign w_pcPlus4  = w_pc + 32'd4;
   assign w_zeroWord = (bus.instr_i == NOP_WORD);

   if_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pcReg (
      .clk_i    (clk_i),
      .rst_n    (rst_n),
      .i_flush  (w_flush),
      .i_hold   (w_hold),
      .i_target (bus.branch_target_i),
      .o_pc     (w_pc)
   );

   // Fetch-state FSM together with the IF/ID register and the done flag.
   // A zero word is latched as a bubble; the cycle that finishes draining is
   // still a fetch cycle but presents no valid instruction.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= RUN;
         r_cnt       <= '0;
         r_ifidInstr <= '0;
         r_ifidPc4   <= '0;
         r_ifidValid <= 1'b0;
         r_done      <= 1'b0;
      end else if (w_flush) begin
         r_state     <= RUN;
         r_cnt       <= '0;
         r_ifidInstr <= '0;
         r_ifidPc4   <= '0;
         r_ifidValid <= 1'b0;
      end else if (w_advance) begin
         r_ifidInstr <= bus.instr_i;
         r_ifidPc4   <= w_pcPlus4;
         r_ifidValid <= !w_zeroWord;
         case (r_state)
            RUN: begin
               if (w_zeroWord) begin
                  r_state <= DRAIN;
                  r_cnt   <= '0;
               end
            end
            DRAIN: begin
               if (r_cnt == CNT_LAST) begin
                  r_state     <= DONE;
                  r_done      <= 1'b1;
                  r_ifidValid <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.pc_o         = w_pc;
   assign bus.ifid_instr_o = r_ifidInstr;
   assign bus.ifid_pc4_o   = r_ifidPc4;
   assign bus.ifid_valid_o = r_ifidValid;
   assign bus.done_o       = r_done;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter DRAIN_CYCLES, default 4, the number of cycles after fetching the all-zero terminator word before done_o asserts.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port stall_i, input, 1 bit: load-use hazard hold request from hazard unit.
REQ-006 The block SHALL have port flush_i, input, 1 bit: branch taken, redirect fetch.
REQ-007 The block SHALL have port branch_target_i, input, 32 bits: redirect address, valid when flush_i=1.
REQ-008 The block SHALL have port instr_i, input, 32 bits: instruction memory read data for address pc_o, combinational.
REQ-009 The block SHALL have port pc_o, output, 32 bits: current fetch address to instruction memory.
REQ-010 The block SHALL have port ifid_instr_o, output, 32 bits: IF/ID instruction register.
REQ-011 The block SHALL have port ifid_pc4_o, output, 32 bits: IF/ID PC+4 register.
REQ-012 The block SHALL have port ifid_valid_o, output, 1 bit: IF/ID holds a real fetched instruction.
REQ-013 The block SHALL have port done_o, output, 1 bit: program fetched and pipeline drained, sticky until reset.

Function
REQ-014 The block SHALL implement states RUN, DRAIN and DONE.
REQ-015 In RUN with no stall and no flush, the block SHALL set PC <= PC+4 (mod 2^32), ifid_instr <= instr_i, ifid_pc4 <= PC+4 and ifid_valid <= 1 on each edge.
REQ-016 Flush SHALL have priority over stall: PC <= {branch_target_i[31:2],2'b00}, ifid_instr <= 0, ifid_valid <= 0, ifid_pc4 <= 0.
REQ-017 Stall without flush SHALL hold PC, ifid_instr, ifid_pc4 and ifid_valid unchanged.
REQ-018 In RUN, latching instr_i==32'h0 without stall or flush SHALL move the state to DRAIN, clear the drain counter, and still register the zero word as a bubble (ifid_valid=0).
REQ-019 In DRAIN, the block SHALL increment the counter each non-stalled cycle while the PC continues to advance, and SHALL move to DONE when the counter reaches DRAIN_CYCLES-1.
REQ-020 A flush in DRAIN SHALL return the state to RUN, clear the counter and apply the redirect of REQ-016.
REQ-021 A stall in DRAIN SHALL freeze the counter.
REQ-022 In DONE, PC and the IF/ID registers SHALL freeze, ifid_valid_o SHALL be 0, done_o SHALL be 1, and stall_i and flush_i SHALL be ignored.
REQ-023 A nonzero word fetched in DRAIN SHALL NOT leave DRAIN, since only a flush re-enters RUN.
REQ-024 pc_o SHALL equal the PC register, giving zero-cycle fetch latency; the IF/ID outputs SHALL lag pc_o by one cycle.
REQ-025 The PC SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 without error.

Reset
REQ-026 While rst_n=0, the block SHALL immediately set pc_o=RESET_PC, ifid_instr_o=0, ifid_pc4_o=0, ifid_valid_o=0, done_o=0, state=RUN and counter=0.
REQ-027 Reset asserted mid-DRAIN or in DONE SHALL discard all progress; the first fetch after release SHALL be at RESET_PC.

Structure
REQ-028 Shared package cpu_pkg SHALL hold the opcode constants (OP_R_TYPE 6'b000000, OP_ADDI 6'b010011, OP_BEQ 6'b011001, OP_LW 6'b011000, OP_SW 6'b101000), the if_state_t enum {RUN, DRAIN, DONE} and the NOP word constant 32'h0.
REQ-029 One sub-module SHALL be used: if_pc_reg, the PC register with next-PC mux (flush target / hold / +4) and alignment masking; the FSM and IF/ID register SHALL be in if_stage.

Verification
REQ-030 Sequential fetch: memory words 0..3 nonzero, no stall -> pc_o 0,4,8,12 on consecutive cycles; ifid_pc4_o 4,8,12,16 one cycle later; ifid_valid_o=1.
REQ-031 Stall: stall_i=1 for 2 cycles at pc_o=8 -> pc_o stays 8 and ifid_instr_o holds word 1 for 2 cycles, then advances to 12.
REQ-032 Flush with simultaneous stall: flush_i=1, stall_i=1, branch_target_i=32'h0000_0022 -> next pc_o=32'h20, ifid_valid_o=0, ifid_instr_o=0.
REQ-033 Drain: word at 16 is 0, DRAIN_CYCLES=4 -> done_o rises 4 cycles after the zero word is latched; pc_o frozen thereafter.
REQ-034 Flush in DRAIN: flush_i=1 with target 4 at the second DRAIN cycle -> state RUN, done_o stays 0, fetch resumes at 4.
REQ-035 Async reset in DONE: rst_n low mid-cycle -> outputs reset immediately, not at the next edge; after release pc_o=0 and done_o=0.
